// File: rtl/idct_8x8_block_if.sv
// Stream interface for idct_8x8_block.
//   in_valid/in_ready/in_coef     : coefficient input stream, row-major F(k1,k2)
//   out_valid/out_ready/out_pixel : pixel output stream, raster order f(n1,n2)
//   out_last                      : marks the 64th pixel of a block
// The slave modport is the IDCT side; the master modport is the producer/consumer side.
interface idct_8x8_block_if #(
  parameter int COEF_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_coef;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_pixel;
  logic                     out_last;

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_pixel, out_last
  );

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/idct_8x8_block.sv
// Inverse 2D DCT for 8x8 blocks, computed by direct 64-term MAC per pixel.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : idct_8x8_block_if.slave (coefficient in / pixel out streams)
//   busy       : high while computing or emitting a block
// Flow: LOAD 64 coefficients -> COMPUTE 64 pixels at 66 cycles each
// (64 MAC issues + 1 accumulate drain + 1 finalise) -> OUTPUT 64 pixels.
// Pixel = clamp(((acc + 2^15) >>> 16) + 128, 0, 255).
module idct_8x8_block #(
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  idct_8x8_block_if.slave       bus,
  output logic                  busy
);

  localparam int PW = COEF_W + 16;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
  state_t state, state_nx;

  logic [5:0] load_cnt, pix_cnt, out_cnt;
  logic [6:0] mac_cnt;

  logic signed [COEF_W-1:0] coef_buf [64];
  logic [7:0]               pix_buf  [64];

  // Cosine basis, scaled by 128 and rounded; cos((2n+1)k*pi/16) is folded
  // onto a 9-entry quarter-wave table using its period-32 symmetry.
  function automatic logic signed [8:0] basis(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]        m, f;
    logic [3:0]        idx;
    logic              neg;
    logic signed [8:0] mag;
    if (k == 3'd0) return 9'sd91;
    m   = 5'(7'({n, 1'b1}) * 7'(k));
    f   = (m > 5'd16) ? 5'(6'd32 - {1'b0, m}) : m;
    neg = (f > 5'd8);
    idx = neg ? 4'(5'd16 - f) : f[3:0];
    case (idx)
      4'd0:    mag = 9'sd128;
      4'd1:    mag = 9'sd126;
      4'd2:    mag = 9'sd118;
      4'd3:    mag = 9'sd106;
      4'd4:    mag = 9'sd91;
      4'd5:    mag = 9'sd71;
      4'd6:    mag = 9'sd49;
      4'd7:    mag = 9'sd25;
      default: mag = 9'sd0;
    endcase
    return neg ? -mag : mag;
  endfunction

  // handshakes
  logic acc_in, acc_out;
  assign acc_in  = bus.in_valid  && (state == LOAD);
  assign acc_out = bus.out_ready && (state == OUTPUT);

  // MAC datapath: stage 1 multiplies, stage 2 accumulates
  logic                     issue, mul_vld;
  logic [5:0]               ci;
  logic signed [8:0]        a_r, a_c;
  logic signed [17:0]       bprod_w;
  logic signed [15:0]       bprod;
  logic signed [PW-1:0]     prod_w, mul_r;
  logic signed [ACC_W-1:0]  acc, rnd_v;
  logic [7:0]               pix_v;

  localparam logic signed [ACC_W-1:0] RND  = 32768;
  localparam logic signed [ACC_W-1:0] OFS  = 128;
  localparam logic signed [ACC_W-1:0] PMAX = 255;

  assign issue   = (state == COMPUTE) && (mac_cnt < 7'd64);
  assign ci      = mac_cnt[5:0];
  assign a_r     = basis(ci[5:3], pix_cnt[5:3]);
  assign a_c     = basis(ci[2:0], pix_cnt[2:0]);
  assign bprod_w = a_r * a_c;
  assign bprod   = bprod_w[15:0];   // |a|<=128 so the product fits in 16 bits
  assign prod_w  = coef_buf[ci] * bprod;

  always_comb begin
    rnd_v = ((acc + RND) >>> 16) + OFS;
    if (rnd_v[ACC_W-1])   pix_v = 8'd0;
    else if (rnd_v > PMAX) pix_v = 8'd255;
    else                   pix_v = rnd_v[7:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (acc_in && load_cnt == 6'd63) state_nx = COMPUTE;
      COMPUTE: if (mac_cnt == 7'd65 && pix_cnt == 6'd63) state_nx = OUTPUT;
      OUTPUT:  if (acc_out && out_cnt == 6'd63) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // outputs; out_pixel is gated so it reads 0 outside OUTPUT (buffers are never cleared)
  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == OUTPUT);
    bus.out_pixel = 8'd0;
    bus.out_last  = 1'b0;
    busy          = (state != LOAD);
    if (state == OUTPUT) begin
      bus.out_pixel = pix_buf[out_cnt];
      bus.out_last  = (out_cnt == 6'd63);
    end
  end

  // counters and MAC pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
      pix_cnt  <= '0;
      mac_cnt  <= '0;
      out_cnt  <= '0;
      mul_vld  <= 1'b0;
      mul_r    <= '0;
      acc      <= '0;
    end else begin
      mul_vld <= issue;
      if (issue) mul_r <= prod_w;
      if (acc_in)  load_cnt <= load_cnt + 6'd1;
      if (acc_out) out_cnt  <= out_cnt + 6'd1;
      if (state == COMPUTE) begin
        if (mac_cnt == 7'd65) begin
          mac_cnt <= '0;
          pix_cnt <= pix_cnt + 6'd1;
          acc     <= '0;
        end else begin
          mac_cnt <= mac_cnt + 7'd1;
          if (mul_vld) acc <= acc + {{(ACC_W-PW){mul_r[PW-1]}}, mul_r};
        end
      end
    end
  end

  // storage (not reset)
  always_ff @(posedge clk) begin
    if (acc_in) coef_buf[load_cnt] <= bus.in_coef;
    if (state == COMPUTE && mac_cnt == 7'd65) pix_buf[pix_cnt] <= pix_v;
  end

endmodule
